// File: rtl/regfile_pkg.sv
// Shared register-file constants for the writeback arbitration slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int XLEN     = 64;
  localparam int AW       = 5;
  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;
  localparam int MAX_NREQ = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selector with a rotating priority pointer.
// Latency: grant is combinational; the pointer advances on the edge after a grant.
// Backpressure: en=0 blocks every grant and freezes the pointer.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST   = IW'(NREQ - 1);

  logic [IW-1:0] ptr;
  logic [IW:0]   pos;
  logic          found;

  // Scan ptr, ptr+1, ... with wraparound; the first requester seen wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= NREQ_W) begin
        pos = pos - NREQ_W;
      end
      if (en && !found && req[pos[IW-1:0]]) begin
        found                = 1'b1;
        gnt[pos[IW-1:0]]     = 1'b1;
        gnt_idx              = pos[IW-1:0];
      end
    end
  end

  // Priority moves to the requester just after the winner; holds when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port among NREQ writeback requesters.
// Latency: a write accepted in cycle T drives rf_* in T+1 (1 cycle).
// Backpressure: requesters wait on req_ready; the output stage itself never stalls.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int AW   = regfile_pkg::AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 flush,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [NUM_REGS-1:0]  pend_mask,
  output logic [31:0]          wr_count
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            arb_en;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  // Grants are suppressed during flush and while reset is asserted.
  assign arb_en    = reset & ~flush;
  assign gnt_any   = |gnt;
  assign req_ready = gnt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Operand mux: pick the winner's destination index and data.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_rd   = req_rd[i*AW +: AW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Output stage: x0 writes complete the handshake but never raise rf_we.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= gnt_any && (sel_rd != AW'(REG_ZERO));
      if (gnt_any) begin
        rf_rd    <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

  // Commit counter, one step per cycle that the register file is written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count <= '0;
    end else if (rf_we) begin
      wr_count <= wr_count + 32'd1;
    end
  end

  // Destinations that are waiting at a requester or sitting in the output stage.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        pend_mask[req_rd[i*AW +: AW]] = 1'b1;
      end
    end
    if (rf_we) begin
      pend_mask[rf_rd] = 1'b1;
    end
    pend_mask[REG_ZERO] = 1'b0;
  end

endmodule
